alu_issue_ctrl: RTL

- Requester-side driver for the datapath ALU, which takes data1, data2 and a 3-bit ALUctrl, and returns alu_result and zero.
- Accepts one decoded instruction at a time over a valid/ready request channel and maps opcode/funct to the ALU control code.
- Registers the operands onto the ALU ports, captures alu_result and zero, and resolves the branch decision.
- Returns everything over a valid/ready response channel. Sits between the decode stage and the ALU in the multi-cycle core.

---
 rtl/alu_issue_ctrl.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/alu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// alu_issue_ctrl : decodes one instruction, drives the ALU, returns result/branch.
// Optional: ALU_OVF_DETECT_EN adds resp_ovf.     Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module alu_issue_ctrl #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [5:0]        req_opcode,
  input  logic [5:0]        req_funct,
  input  logic [DATA_W-1:0] req_op_a,
  input  logic [DATA_W-1:0] req_op_b,
  input  logic [TAG_W-1:0]  req_tag,
  output logic [DATA_W-1:0] alu_data1,
  output logic [DATA_W-1:0] alu_data2,
  output logic [2:0]        alu_ctrl,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_result,
  output logic              resp_zero,
  output logic              resp_taken,
  output logic              resp_illegal,
  output logic [TAG_W-1:0]  resp_tag
`ifdef ALU_OVF_DETECT_EN
  ,
  output logic              resp_ovf
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [1:0] BR_NONE = 2'd0;
  localparam logic [1:0] BR_EQ   = 2'd1;
  localparam logic [1:0] BR_NE   = 2'd2;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SLL = 3'b100;
  localparam logic [2:0] OP_SRL = 3'b101;

  state_t            state_q, state_d;
  logic              req_ready_q, req_ready_d;
  logic [DATA_W-1:0] alu_data1_q, alu_data1_d;
  logic [DATA_W-1:0] alu_data2_q, alu_data2_d;
  logic [2:0]        alu_ctrl_q, alu_ctrl_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [1:0]        br_q, br_d;
  logic              resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0] resp_result_q, resp_result_d;
  logic              resp_zero_q, resp_zero_d;
  logic              resp_taken_q, resp_taken_d;
  logic              resp_illegal_q, resp_illegal_d;
  logic              ovf_q, ovf_d;
  logic              exec_ovf;

  logic [2:0]        dec_code;
  logic              dec_legal;
  logic [1:0]        dec_br;

  always_comb begin
    dec_code  = OP_ADD;
    dec_legal = 1'b0;
    dec_br    = BR_NONE;
    case (req_opcode)
      6'b000000: begin
        dec_legal = 1'b1;
        case (req_funct)
          6'b100000: dec_code = OP_ADD;
          6'b100010: dec_code = OP_SUB;
          6'b100100: dec_code = OP_AND;
          6'b100101: dec_code = OP_OR;
          6'b000000: dec_code = OP_SLL;
          6'b000010: dec_code = OP_SRL;
          default:   dec_legal = 1'b0;
        endcase
      end
      6'b001000, 6'b100011, 6'b101011: begin
        dec_code  = OP_ADD;
        dec_legal = 1'b1;
      end
      6'b001100: begin
        dec_code  = OP_AND;
        dec_legal = 1'b1;
      end
      6'b001101: begin
        dec_code  = OP_OR;
        dec_legal = 1'b1;
      end
      6'b000100: begin
        dec_code  = OP_SUB;
        dec_legal = 1'b1;
        dec_br    = BR_EQ;
      end
      6'b000101: begin
        dec_code  = OP_SUB;
        dec_legal = 1'b1;
        dec_br    = BR_NE;
      end
      default: dec_legal = 1'b0;
    endcase
  end

`ifdef ALU_OVF_DETECT_EN
  // For subtract the effective second operand is negated, so its sign flips.
  logic b_sign_eff;
  assign b_sign_eff = (alu_ctrl_q == OP_SUB) ? ~alu_data2_q[DATA_W-1] : alu_data2_q[DATA_W-1];
  assign exec_ovf   = ((alu_ctrl_q == OP_ADD) || (alu_ctrl_q == OP_SUB))
                   && (alu_data1_q[DATA_W-1] == b_sign_eff)
                   && (alu_result[DATA_W-1] != alu_data1_q[DATA_W-1]);
`else
  assign exec_ovf = 1'b0;
`endif

  always_comb begin
    state_d        = state_q;
    req_ready_d    = req_ready_q;
    alu_data1_d    = alu_data1_q;
    alu_data2_d    = alu_data2_q;
    alu_ctrl_d     = alu_ctrl_q;
    tag_d          = tag_q;
    br_d           = br_q;
    resp_valid_d   = resp_valid_q;
    resp_result_d  = resp_result_q;
    resp_zero_d    = resp_zero_q;
    resp_taken_d   = resp_taken_q;
    resp_illegal_d = resp_illegal_q;
    ovf_d          = ovf_q;
    case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          tag_d       = req_tag;
          br_d        = dec_br;
          req_ready_d = 1'b0;
          if (dec_legal) begin
            alu_data1_d = req_op_a;
            alu_data2_d = req_op_b;
            alu_ctrl_d  = dec_code;
            state_d     = EXEC;
          end else begin
            // ALU port registers keep their previous values on illegal ops.
            resp_valid_d   = 1'b1;
            resp_result_d  = '0;
            resp_zero_d    = 1'b0;
            resp_taken_d   = 1'b0;
            resp_illegal_d = 1'b1;
            ovf_d          = 1'b0;
            state_d        = RESP;
          end
        end
      end
      EXEC: begin
        resp_valid_d   = 1'b1;
        resp_result_d  = alu_result;
        resp_zero_d    = alu_zero;
        resp_taken_d   = (br_q == BR_EQ) ? alu_zero :
                         (br_q == BR_NE) ? ~alu_zero : 1'b0;
        resp_illegal_d = 1'b0;
        ovf_d          = exec_ovf;
        state_d        = RESP;
      end
      RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          req_ready_d  = 1'b1;
          state_d      = IDLE;
        end
      end
      default: begin
        state_d      = IDLE;
        req_ready_d  = 1'b1;
        resp_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      req_ready_q    <= 1'b1;
      alu_data1_q    <= '0;
      alu_data2_q    <= '0;
      alu_ctrl_q     <= 3'b000;
      tag_q          <= '0;
      br_q           <= BR_NONE;
      resp_valid_q   <= 1'b0;
      resp_result_q  <= '0;
      resp_zero_q    <= 1'b0;
      resp_taken_q   <= 1'b0;
      resp_illegal_q <= 1'b0;
      ovf_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      req_ready_q    <= req_ready_d;
      alu_data1_q    <= alu_data1_d;
      alu_data2_q    <= alu_data2_d;
      alu_ctrl_q     <= alu_ctrl_d;
      tag_q          <= tag_d;
      br_q           <= br_d;
      resp_valid_q   <= resp_valid_d;
      resp_result_q  <= resp_result_d;
      resp_zero_q    <= resp_zero_d;
      resp_taken_q   <= resp_taken_d;
      resp_illegal_q <= resp_illegal_d;
      ovf_q          <= ovf_d;
    end
  end

  assign req_ready    = req_ready_q;
  assign alu_data1    = alu_data1_q;
  assign alu_data2    = alu_data2_q;
  assign alu_ctrl     = alu_ctrl_q;
  assign resp_valid   = resp_valid_q;
  assign resp_result  = resp_result_q;
  assign resp_zero    = resp_zero_q;
  assign resp_taken   = resp_taken_q;
  assign resp_illegal = resp_illegal_q;
  assign resp_tag     = tag_q;
`ifdef ALU_OVF_DETECT_EN
  assign resp_ovf     = ovf_q;
`else
  logic unused_ovf;
  assign unused_ovf = ovf_q ^ exec_ovf;
`endif

endmodule

`default_nettype wire
